pll_supervisor: RTL

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

---
 rtl/pll_supervisor.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pll_supervisor.sv
// PLL supervisor: sequences PLL reset, lock qualification, retries and bypass
// for a PLL clocked from its own reference clock.
//   state     | meaning
//   HOLD      | PLL held in reset for RESET_HOLD cycles
//   WAIT_LOCK | reset released, waiting for synchronised lock
//   FILTER    | lock must stay high LOCK_FILTER cycles
//   RUN       | clock usable
//   FAULT     | retries exhausted, PLL held in reset until RESET
//   BYPASS    | PLL bypassed on request
module pll_supervisor #(
  parameter int RESET_HOLD   = 16,
  parameter int LOCK_FILTER  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3,
  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1)
) (
  input  logic          REFERENCECLK,
  input  logic          RESET,
  input  logic          PLL_LOCK,
  input  logic          BYPASS_REQ,
  output logic          PLL_RESETB,
  output logic          PLL_BYPASS,
  output logic          CLK_READY,
  output logic          FAULT,
  output logic          LOST,
  output logic [RW-1:0] RETRY_COUNT,
  output logic [2:0]    STATE
);

  localparam int CMAX_A = (RESET_HOLD > LOCK_FILTER) ? RESET_HOLD : LOCK_FILTER;
  localparam int CMAX   = (CMAX_A > LOCK_TIMEOUT) ? CMAX_A : LOCK_TIMEOUT;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD - 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT   = 3'd1,
    S_FILTER = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4,
    S_BYPASS = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          lost_q, lost_d;
  logic          lock_meta_q, lock_s_q;
  logic          resetb_q, resetb_d;
  logic          bypass_q, bypass_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic          fail;

  always_ff @(posedge REFERENCECLK or posedge RESET) begin
    if (RESET) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= PLL_LOCK;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge REFERENCECLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      retry_q  <= '0;
      lost_q   <= 1'b0;
      resetb_q <= 1'b0;
      bypass_q <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      lost_q   <= lost_d;
      resetb_q <= resetb_d;
      bypass_q <= bypass_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    fail    = 1'b0;

    if (BYPASS_REQ && (state_q != S_FAULT)) begin
      state_d = S_BYPASS;
    end else begin
      case (state_q)
        S_HOLD:   if (cnt_q == HOLD_LAST) state_d = S_WAIT;
        S_WAIT: begin
          if (lock_s_q)              state_d = S_FILTER;
          else if (cnt_q == TO_LAST) fail    = 1'b1;
        end
        S_FILTER: begin
          if (!lock_s_q)               state_d = S_WAIT;
          else if (cnt_q == FILT_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_d = S_HOLD;
            lost_d  = 1'b1;
          end
        end
        S_FAULT:  state_d = S_FAULT;
        S_BYPASS: state_d = S_HOLD;
        default:  state_d = S_HOLD;
      endcase
    end

    if (fail) begin
      if ((MAX_RETRY != 0) && (retry_q == RETRY_LIM)) begin
        state_d = S_FAULT;
      end else begin
        state_d = S_HOLD;
        if (retry_q != '1) retry_d = retry_q + RW'(1);
      end
    end

    if ((state_d == S_RUN) || (state_d == S_BYPASS)) retry_d = '0;

    // counter restarts on every state change and saturates in long-lived states
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + CW'(1);
    else                     cnt_d = cnt_q;

    resetb_d = !((state_d == S_HOLD) || (state_d == S_FAULT));
    bypass_d = (state_d == S_BYPASS);
    ready_d  = (state_d == S_RUN) || (state_d == S_BYPASS);
    fault_d  = (state_d == S_FAULT);
  end

  assign PLL_RESETB  = resetb_q;
  assign PLL_BYPASS  = bypass_q;
  assign CLK_READY   = ready_q;
  assign FAULT       = fault_q;
  assign LOST        = lost_q;
  assign RETRY_COUNT = retry_q;
  assign STATE       = state_q;

endmodule
